// File: rtl/multiword_add_sequencer_pkg.sv
// Shared constants and types for the multi-word add/sub sequencer.
package multiword_add_sequencer_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice-index width; a single-slice build still needs a 1-bit index.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// 8-bit ripple-carry adder with carry-out and signed-overflow flag.
module ripple_carry_adder
  import multiword_add_sequencer_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              overflow
);

  logic [BYTE_W:0]   carry;
  logic [BYTE_W-1:0] sum_bits;

  always_comb begin
    carry    = '0;
    sum_bits = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
      carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign sum      = sum_bits;
  assign cout     = carry[BYTE_W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry[BYTE_W] ^ carry[BYTE_W-1];

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/sub controller: one shared 8-bit adder walks WORDS
// byte slices LSB first, chaining the carry through carry_reg.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned WORDS = 4
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [BYTE_W*WORDS-1:0]   a,
  input  logic [BYTE_W*WORDS-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [BYTE_W*WORDS-1:0]   result,
  output logic                      cout,
  output logic                      overflow,
  output logic                      zero
);

  localparam int unsigned N     = BYTE_W * WORDS;
  localparam int unsigned IDX_W = idx_width(WORDS);

  state_t             state, state_next;
  logic [N-1:0]       opa, opa_next;
  logic [N-1:0]       opb, opb_next;
  logic               carry_reg, carry_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic [N-1:0]       result_next;
  logic               cout_next, overflow_next, zero_next;
  logic               busy_next, done_next;

  logic [BYTE_W-1:0]  slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_ovf;
  logic               last;

  assign slice_a = opa[BYTE_W*32'(idx) +: BYTE_W];
  assign slice_b = opb[BYTE_W*32'(idx) +: BYTE_W];
  assign last    = (idx == IDX_W'(WORDS - 1));

  ripple_carry_adder u_adder (
    .a        (slice_a),
    .b        (slice_b),
    .cin      (carry_reg),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .overflow (slice_ovf)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    opa_next      = opa;
    opb_next      = opb;
    carry_next    = carry_reg;
    idx_next      = idx;
    result_next   = result;
    cout_next     = cout;
    overflow_next = overflow;
    zero_next     = zero;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    unique case (state)
      IDLE: begin
        if (start) begin
          opa_next      = a;
          opb_next      = op_sub ? ~b : b;
          carry_next    = op_sub ? 1'b1 : cin;
          idx_next      = '0;
          result_next   = '0;
          cout_next     = 1'b0;
          overflow_next = 1'b0;
          zero_next     = 1'b0;
        end
      end
      RUN: begin
        result_next[BYTE_W*32'(idx) +: BYTE_W] = slice_sum;
        carry_next = slice_cout;
        if (last) begin
          // Flags are final once the top slice is written.
          cout_next     = slice_cout;
          overflow_next = slice_ovf;
          zero_next     = (result_next == '0);
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opa       <= '0;
      opb       <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      opa       <= opa_next;
      opb       <= opb_next;
      carry_reg <= carry_next;
      idx       <= idx_next;
      result    <= result_next;
      cout      <= cout_next;
      overflow  <= overflow_next;
      zero      <= zero_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer (WORDS=4 and WORDS=1).
module tb_multiword_add_sequencer;

  logic        clk;
  logic        rst;

  logic        start, op_sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, overflow, zero;
  logic [31:0] result;

  logic        start1, op_sub1, cin1;
  logic [7:0]  a1, b1;
  logic        busy1, done1, cout1, overflow1, zero1;
  logic [7:0]  result1;

  int n_checks;
  int n_fail;

  multiword_add_sequencer #(.WORDS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow), .zero(zero)
  );

  multiword_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(op_sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(overflow1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation on the WORDS=4 instance, checking latency and all result flags.
  task automatic do_op(input string tag, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic c, input logic [31:0] exp_res,
                       input logic exp_cout, input logic exp_ovf, input logic exp_zero);
    int cyc;
    op_sub = s; a = x; b = y; cin = c; start = 1'b1;
    step();
    start = 1'b0; a = ~x; b = ~y; cin = ~c;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_res_clr"}, result, 0);
    chk({tag, "_flags_clr"}, {cout, overflow, zero}, 0);
    cyc = 1;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_result"}, result, exp_res);
    chk({tag, "_cout"}, cout, exp_cout);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    chk({tag, "_zero"}, zero, exp_zero);
    step();
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    int cyc;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    start = 1'b0; op_sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    start1 = 1'b0; op_sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
    step();
    step();
    rst = 1'b0;
    step();

    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {cout, overflow, zero}, 0);
    chk("rst_w1", {busy1, done1, cout1, overflow1, zero1}, 0);

    do_op("carry_chain", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    do_op("sovf",        1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    do_op("add_cin",     1'b0, 32'h12345678, 32'h0FEDCBA8, 1'b1, 32'h22222221, 1'b0, 1'b0, 1'b0);
    do_op("sub_borrow",  1'b1, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    do_op("sub_ovf",     1'b1, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    do_op("sub_cin_ign", 1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    do_op("sub_eq",      1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);

    // start held for 8 cycles with changing operands; vector k is on the bus at edge k
    for (int k = 0; k < 8; k++) begin
      start = 1'b1; op_sub = 1'b0; cin = 1'b0;
      if (k == 0) begin
        a = 32'h11111111; b = 32'h11111111;
      end else if (k == 6) begin
        a = 32'h01000000; b = 32'h00FF0000;
      end else begin
        a = 32'hFFFF0000 | 32'(k); b = 32'(k);
      end
      step();
      chk("hold_done", done, 32'(k + 1 == 5));
      if (k + 1 == 5) chk("hold_res1", result, 32'h22222222);
      if (k + 1 == 6) chk("hold_idle", busy, 0);
      if (k + 1 == 7) chk("hold_reaccept", busy, 1);
    end
    start = 1'b0;
    for (int c = 9; c <= 11; c++) begin
      step();
      chk("hold_done2", done, 32'(c == 11));
    end
    chk("hold_res2", result, 32'h01FF0000);
    step();
    chk("hold_single", done, 0);

    // reset in the second RUN cycle discards the operation
    a = 32'h01010101; b = 32'h01010101; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_partial", result, 32'h00000002);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", busy, 0);
    chk("mid_result", result, 0);
    chk("mid_done", done, 0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mid_nodone", done, 0);
    end
    do_op("after_rst", 1'b0, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);

    // single-slice build
    a1 = 8'h80; b1 = 8'h80; op_sub1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    chk("w1_busy", busy1, 1);
    cyc = 1;
    while (!done1 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("w1_latency", cyc, 2);
    chk("w1_result", result1, 0);
    chk("w1_cout", cout1, 1);
    chk("w1_ovf", overflow1, 1);
    chk("w1_zero", zero1, 1);
    step();
    chk("w1_done_off", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
